// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: parametrised UART transmitter, one bit per CLK (baud clock).
// Frame = start(0), DATA_WIDTH data bits (LSB or MSB first), optional parity,
// then one or two stop bits (1). Word, parity and framing options are latched
// at acceptance, so the source may change them while the frame is on the line.
//
// Handshake: a word is accepted on a rising CLK edge where Data_Valid && tx_ready.
// tx_ready is high in IDLE and in the final stop-bit cycle, which allows
// back-to-back frames with no idle gap. Data_Valid while tx_ready is low is
// ignored (no queueing). START begins on the cycle after acceptance.
//
// All outputs are flops computed from the next state, so TX_OUT is glitch-free
// and the async reset drives the line high immediately.
module uart_tx_cfg #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  parity_enable,
  input  logic                  parity_type,
  input  logic                  stop_two,
  input  logic                  msb_first,
  output logic                  tx_ready,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  TX_OUT,
  output logic [2:0]            dbg_state
);

  localparam int IDX_W = $clog2(DATA_WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  stop_cnt_q, stop_cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  par_en_q, par_en_d;
  logic                  par_odd_q, par_odd_d;
  logic                  stop_two_q, stop_two_d;
  logic                  msb_first_q, msb_first_d;
  logic                  tx_out_q, tx_out_d;
  logic                  busy_q, busy_d;
  logic                  tx_ready_q, tx_ready_d;
  logic                  frame_done_q, frame_done_d;

  logic                  accept;
  logic [IDX_W-1:0]      bit_sel;
  logic                  last_stop_d;

  // Next-state, config latching and next-cycle output decode.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    stop_cnt_d  = stop_cnt_q;
    data_d      = data_q;
    par_en_d    = par_en_q;
    par_odd_d   = par_odd_q;
    stop_two_d  = stop_two_q;
    msb_first_d = msb_first_q;
    tx_out_d    = 1'b1;
    bit_sel     = '0;
    last_stop_d = 1'b0;

    // tx_ready_q is only high in IDLE or in the final stop cycle.
    accept = Data_Valid && tx_ready_q;

    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_START;
      end
      S_START: begin
        state_d = S_DATA;
        idx_d   = '0;
      end
      S_DATA: begin
        if (idx_q == LAST_IDX) begin
          state_d    = par_en_q ? S_PARITY : S_STOP;
          stop_cnt_d = 1'b0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_PARITY: begin
        state_d    = S_STOP;
        stop_cnt_d = 1'b0;
      end
      S_STOP: begin
        if (stop_cnt_q == stop_two_q) state_d = accept ? S_START : S_IDLE;
        else                          stop_cnt_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      data_d      = P_DATA;
      par_en_d    = parity_enable;
      par_odd_d   = parity_type;
      stop_two_d  = stop_two;
      msb_first_d = msb_first;
    end

    bit_sel = msb_first_d ? (LAST_IDX - idx_d) : idx_d;

    case (state_d)
      S_START:  tx_out_d = 1'b0;
      S_DATA:   tx_out_d = data_d[bit_sel];
      S_PARITY: tx_out_d = par_odd_d ? ~^data_d : ^data_d;
      default:  tx_out_d = 1'b1;
    endcase

    last_stop_d  = (state_d == S_STOP) && (stop_cnt_d == stop_two_d);
    busy_d       = (state_d != S_IDLE);
    tx_ready_d   = (state_d == S_IDLE) || last_stop_d;
    frame_done_d = last_stop_d;
  end

  // State, latched frame config and registered outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      stop_cnt_q   <= 1'b0;
      data_q       <= '0;
      par_en_q     <= 1'b0;
      par_odd_q    <= 1'b0;
      stop_two_q   <= 1'b0;
      msb_first_q  <= 1'b0;
      tx_out_q     <= 1'b1;
      busy_q       <= 1'b0;
      tx_ready_q   <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      stop_cnt_q   <= stop_cnt_d;
      data_q       <= data_d;
      par_en_q     <= par_en_d;
      par_odd_q    <= par_odd_d;
      stop_two_q   <= stop_two_d;
      msb_first_q  <= msb_first_d;
      tx_out_q     <= tx_out_d;
      busy_q       <= busy_d;
      tx_ready_q   <= tx_ready_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign TX_OUT     = tx_out_q;
  assign busy       = busy_q;
  assign tx_ready   = tx_ready_q;
  assign frame_done = frame_done_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: three builds (DATA_WIDTH 8, 5, 16) on a shared clock,
// reset and framing config. Expected line bits come from a frame builder that
// assembles start/data/parity/stop bits straight from the word and options.
module tb_uart_tx_cfg;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic pe = 1'b0, pt = 1'b0, st = 1'b0, mf = 1'b0;

  logic [7:0]  data8  = '0;
  logic [4:0]  data5  = '0;
  logic [15:0] data16 = '0;
  logic dv8 = 1'b0, dv5 = 1'b0, dv16 = 1'b0;
  logic rdy8, busy8, done8, tx8;
  logic rdy5, busy5, done5, tx5;
  logic rdy16, busy16, done16, tx16;
  logic [2:0] st8, st5, st16;

  logic [0:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  uart_tx_cfg #(.DATA_WIDTH(8)) dut8 (
    .CLK(CLK), .RST(RST), .P_DATA(data8), .Data_Valid(dv8),
    .parity_enable(pe), .parity_type(pt), .stop_two(st), .msb_first(mf),
    .tx_ready(rdy8), .busy(busy8), .frame_done(done8), .TX_OUT(tx8), .dbg_state(st8)
  );

  uart_tx_cfg #(.DATA_WIDTH(5)) dut5 (
    .CLK(CLK), .RST(RST), .P_DATA(data5), .Data_Valid(dv5),
    .parity_enable(pe), .parity_type(pt), .stop_two(st), .msb_first(mf),
    .tx_ready(rdy5), .busy(busy5), .frame_done(done5), .TX_OUT(tx5), .dbg_state(st5)
  );

  uart_tx_cfg #(.DATA_WIDTH(16)) dut16 (
    .CLK(CLK), .RST(RST), .P_DATA(data16), .Data_Valid(dv16),
    .parity_enable(pe), .parity_type(pt), .stop_two(st), .msb_first(mf),
    .tx_ready(rdy16), .busy(busy16), .frame_done(done16), .TX_OUT(tx16), .dbg_state(st16)
  );

  function automatic int width_of(input int sel);
    return (sel == 1) ? 5 : (sel == 2) ? 16 : 8;
  endfunction

  task automatic set_dv(input int sel, input logic v, input logic [15:0] d);
    case (sel)
      1:       begin dv5  = v; data5  = d[4:0]; end
      2:       begin dv16 = v; data16 = d;      end
      default: begin dv8  = v; data8  = d[7:0]; end
    endcase
  endtask

  task automatic sample(input int sel, output logic t, output logic b,
                        output logic r, output logic fd);
    case (sel)
      1:       begin t = tx5;  b = busy5;  r = rdy5;  fd = done5;  end
      2:       begin t = tx16; b = busy16; r = rdy16; fd = done16; end
      default: begin t = tx8;  b = busy8;  r = rdy8;  fd = done8;  end
    endcase
  endtask

  // Reference frame: start 0, data bits in requested order, parity making the
  // total count of ones even (or odd), then 1 or 2 stop bits.
  task automatic build_expected(input int w, input logic [15:0] d, input logic cpe,
                                input logic cpt, input logic cst, input logic cmf);
    int ones = 0;
    logic b;
    exp_q.push_back(1'b0);
    for (int i = 0; i < w; i++) begin
      b = cmf ? d[w-1-i] : d[i];
      ones += int'(b);
      exp_q.push_back(b);
    end
    if (cpe) begin
      b = (ones % 2) == 1;
      exp_q.push_back(cpt ? ~b : b);
    end
    exp_q.push_back(1'b1);
    if (cst) exp_q.push_back(1'b1);
  endtask

  task automatic check_idle(input int sel, input string tag);
    logic t, b, r, fd;
    sample(sel, t, b, r, fd);
    n_checks++;
    if (t !== 1'b1 || b !== 1'b0 || r !== 1'b1 || fd !== 1'b0) begin
      n_fail++;
      $display("FAIL %s idle w%0d: tx=%b busy=%b rdy=%b done=%b, required 1 0 1 0",
               tag, width_of(sel), t, b, r, fd);
    end
  endtask

  // Send one word and compare every cycle of the frame against the model.
  // change_mid scrambles word/config during the frame; noise raises
  // Data_Valid with junk while tx_ready is low.
  task automatic run_frame(input int sel, input logic [15:0] d, input logic cpe,
                           input logic cpt, input logic cst, input logic cmf,
                           input bit change_mid, input bit noise, input string tag);
    logic t, b, r, fd;
    int f;
    int waited = 0;
    sample(sel, t, b, r, fd);
    while (r !== 1'b1 && waited < 50) begin
      @(negedge CLK);
      waited++;
      sample(sel, t, b, r, fd);
    end
    if (r !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s ready_timeout: tx_ready=%b after 50 cycles, required 1", tag, r);
      return;
    end
    pe = cpe; pt = cpt; st = cst; mf = cmf;
    set_dv(sel, 1'b1, d);
    exp_q.delete();
    build_expected(width_of(sel), d, cpe, cpt, cst, cmf);
    f = exp_q.size();
    for (int i = 0; i < f; i++) begin
      @(negedge CLK);
      sample(sel, t, b, r, fd);
      if (i == 0) set_dv(sel, 1'b0, d);
      if (change_mid && i == 2) begin
        pe = ~cpe; pt = ~cpt; st = ~cst; mf = ~cmf;
        set_dv(sel, 1'b0, 16'($urandom));
      end
      if (noise && i >= 1 && i <= f - 3) set_dv(sel, 1'b1, 16'($urandom));
      if (noise && i == f - 2) set_dv(sel, 1'b0, d);
      n_checks++;
      if (t !== exp_q[i]) begin
        n_fail++;
        $display("FAIL %s tx_bit%0d: got %b, required %b", tag, i, t, exp_q[i]);
      end
      n_checks++;
      if (b !== 1'b1) begin
        n_fail++;
        $display("FAIL %s busy_cyc%0d: got %b, required 1", tag, i, b);
      end
      n_checks++;
      if (fd !== (i == f - 1) || r !== (i == f - 1)) begin
        n_fail++;
        $display("FAIL %s done_ready_cyc%0d: done=%b rdy=%b, required %b", tag, i, fd, r,
                 (i == f - 1));
      end
    end
    @(negedge CLK);
    check_idle(sel, tag);
  endtask

  task automatic test_reset;
    logic t, b, r, fd;
    check_idle(0, "reset_hold");
    check_idle(1, "reset_hold");
    check_idle(2, "reset_hold");
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    // Start a frame, then reset asynchronously in the middle of DATA.
    set_dv(0, 1'b1, 16'h00);
    repeat (4) begin
      @(negedge CLK);
      set_dv(0, 1'b0, 16'h00);
    end
    sample(0, t, b, r, fd);
    n_checks++;
    if (t !== 1'b0 || b !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_pre mid_frame: tx=%b busy=%b, required 0 1", t, b);
    end
    #2 RST = 1'b0;
    #1 check_idle(0, "reset_async");
    // Data_Valid held across an edge while reset is asserted: nothing accepted.
    set_dv(0, 1'b1, 16'hA5);
    @(negedge CLK);
    check_idle(0, "reset_dv");
    set_dv(0, 1'b0, 16'h00);
    RST = 1'b1;
    @(negedge CLK);
    check_idle(0, "reset_release");
  endtask

  task automatic test_basic;
    run_frame(0, 16'h00A5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "basic_a5");
  endtask

  task automatic test_parity;
    run_frame(0, 16'h0003, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "parity_even");
    run_frame(0, 16'h0003, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "parity_odd");
    run_frame(0, 16'h0003, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "parity_stop2");
  endtask

  task automatic test_msb;
    run_frame(0, 16'h0080, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "msb_80");
    run_frame(0, 16'h0080, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "msb_midchange");
  endtask

  // Two words with Data_Valid held: second START directly after first stop.
  task automatic b2b_pair(input logic [7:0] w1, input logic [7:0] w2, input logic cpe,
                          input logic cpt, input logic cst, input logic cmf, input string tag);
    logic t, b, r, fd;
    int f1, tot;
    pe = cpe; pt = cpt; st = cst; mf = cmf;
    set_dv(0, 1'b1, {8'h00, w1});
    exp_q.delete();
    build_expected(8, {8'h00, w1}, cpe, cpt, cst, cmf);
    f1 = exp_q.size();
    build_expected(8, {8'h00, w2}, cpe, cpt, cst, cmf);
    tot = exp_q.size();
    for (int i = 0; i < tot; i++) begin
      @(negedge CLK);
      sample(0, t, b, r, fd);
      if (i == 0) set_dv(0, 1'b1, {8'h00, w2});
      if (i == f1) set_dv(0, 1'b0, 16'h0);
      n_checks++;
      if (t !== exp_q[i] || b !== 1'b1) begin
        n_fail++;
        $display("FAIL %s cyc%0d: tx=%b busy=%b, required %b 1", tag, i, t, b, exp_q[i]);
      end
      n_checks++;
      if (fd !== (i == f1 - 1 || i == tot - 1) || r !== (i == f1 - 1 || i == tot - 1)) begin
        n_fail++;
        $display("FAIL %s done_cyc%0d: done=%b rdy=%b, required %b", tag, i, fd, r,
                 (i == f1 - 1 || i == tot - 1));
      end
    end
    @(negedge CLK);
    check_idle(0, tag);
  endtask

  task automatic test_back_to_back;
    b2b_pair(8'h55, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, "b2b_55_ff");
    b2b_pair(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'b1,
             1'($urandom), "b2b_rand");
  endtask

  task automatic test_widths;
    run_frame(1, 16'h0016, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "w5_plain");
    run_frame(2, 16'hC3A1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "w16_plain");
    run_frame(1, 16'($urandom), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "w5_parity");
    run_frame(2, 16'($urandom), 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "w16_parity");
  endtask

  task automatic test_random;
    for (int n = 0; n < 24; n++) begin
      run_frame($urandom_range(0, 2), 16'($urandom), 1'($urandom), 1'($urandom),
                1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), "random");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge CLK);
    test_reset;
    test_basic;
    test_parity;
    test_msb;
    test_back_to_back;
    test_widths;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
